// File: rtl/frac_lut4_cfg_loader.sv
// Bit-serial configuration loader for a group of frac_lut4 cells: shadows a frame, then commits all masks at once.
// Optional per-LUT even parity is enabled by defining FRAC_LUT_CFG_PARITY_EN.
module frac_lut4_cfg_loader #(
    parameter int NUM_LUTS = 4,
    parameter int LUT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_din,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      cfg_busy,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic [NUM_LUTS*LUT_W-1:0] lut_cfg,
    output logic [1:0]                state_dbg
);

`ifdef FRAC_LUT_CFG_PARITY_EN
    localparam int BPL = LUT_W + 1;
`else
    localparam int BPL = LUT_W;
`endif
    localparam int LW = $clog2(NUM_LUTS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [4:0]                bit_cnt;
    logic [LW-1:0]             lut_cnt;
    logic [NUM_LUTS*LUT_W-1:0] shadow;
    logic                      err_acc;
    logic                      restart, accept, last_bit, last_lut, data_bit;
    int                        wr_idx;

    // Handshake: a bit transfers on a rising edge where cfg_valid && cfg_ready;
    // cfg_ready is a registered flag that is high only in SHIFT, and a
    // cfg_start in the same cycle takes priority so that bit is dropped.
    always_comb begin
        restart  = cfg_start && (state != CHECK);
        accept   = cfg_valid && cfg_ready && !cfg_start;
        last_bit = (bit_cnt == 5'(BPL - 1));
        last_lut = (lut_cnt == LW'(NUM_LUTS - 1));
        data_bit = (int'(bit_cnt) < LUT_W);
        wr_idx   = int'(lut_cnt) * LUT_W + int'(bit_cnt);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = SHIFT;
            SHIFT: begin
                if (cfg_start)                             state_nxt = SHIFT;
                else if (accept && last_bit && last_lut)   state_nxt = CHECK;
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            bit_cnt   <= '0;
            lut_cnt   <= '0;
            shadow    <= '0;
            lut_cfg   <= '0;
        end else begin
            state     <= state_nxt;
            cfg_ready <= (state_nxt == SHIFT);
            cfg_busy  <= (state_nxt != IDLE);
            cfg_done  <= 1'b0;
            if (restart) begin
                bit_cnt <= '0;
                lut_cnt <= '0;
                shadow  <= '0;
                cfg_err <= 1'b0;
            end else if (accept) begin
                if (last_bit) begin
                    bit_cnt <= '0;
                    lut_cnt <= lut_cnt + LW'(1);
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
                // Parity slots (bit_cnt == LUT_W) are never written to the shadow.
                for (int i = 0; i < NUM_LUTS * LUT_W; i++) begin
                    if (data_bit && (wr_idx == i)) shadow[i] <= cfg_din;
                end
            end else if (state == CHECK) begin
                if (!err_acc) begin
                    lut_cfg  <= shadow;
                    cfg_done <= 1'b1;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end
        end
    end

`ifdef FRAC_LUT_CFG_PARITY_EN
    logic par_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_acc <= 1'b0;
            err_acc <= 1'b0;
        end else if (restart) begin
            par_acc <= 1'b0;
            err_acc <= 1'b0;
        end else if (accept) begin
            if (last_bit) begin
                if (par_acc ^ cfg_din) err_acc <= 1'b1;
                par_acc <= 1'b0;
            end else begin
                par_acc <= par_acc ^ cfg_din;
            end
        end
    end
`else
    assign err_acc = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_frac_lut4_cfg_loader.sv
// Randomized bench for frac_lut4_cfg_loader: frames are built from masks and compared against a packed-mask model.
// Define FRAC_LUT_CFG_PARITY_EN to also exercise the parity-error path.
module tb_frac_lut4_cfg_loader;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TW = N * W;
`ifdef FRAC_LUT_CFG_PARITY_EN
    localparam int BPL = 17;
    localparam bit PAR = 1'b1;
`else
    localparam int BPL = 16;
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_din = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready, cfg_busy, cfg_done, cfg_err;
    logic [TW-1:0] lut_cfg;
    logic [1:0]    state_dbg;

    int            checks = 0;
    int            failures = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] committed = '0;

    frac_lut4_cfg_loader #(.NUM_LUTS(N), .LUT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_din(cfg_din),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_err(cfg_err), .lut_cfg(lut_cfg), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] pack_masks(input logic [W-1:0] m [N]);
        logic [TW-1:0] r = '0;
        for (int i = 0; i < N; i++) r = r | (TW'(m[i]) << (i * W));
        return r;
    endfunction

    task automatic start_pulse(input bit first_bit);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_din   = ~first_bit;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check_eq("ready_after_start", TW'(cfg_ready), TW'(1));
        check_eq("busy_after_start", TW'(cfg_busy), TW'(1));
        check_eq("err_cleared_at_start", TW'(cfg_err), TW'(0));
    endtask

    task automatic send_partial(input int nbits);
        start_pulse(1'b0);
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = 1'($urandom_range(1));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check_eq("partial_no_commit", lut_cfg, committed);
    endtask

    task automatic run_frame(input logic [W-1:0] m [N], input int duty, input int bad_lut,
                             input bit start_in_check);
        bit            bits[$];
        bit            par;
        bit            good;
        int            idx = 0;
        int            cyc = 0;
        logic [TW-1:0] prev = committed;
        logic [TW-1:0] exp_v;
        for (int i = 0; i < N; i++) begin
            par = 1'b0;
            for (int b = 0; b < W; b++) begin
                bits.push_back(m[i][b]);
                par ^= m[i][b];
            end
            if (PAR) bits.push_back(par ^ (i == bad_lut));
        end
        good = !(PAR && bad_lut >= 0 && bad_lut < N);
        if (good) exp_q.push_back(pack_masks(m));
        start_pulse(bits[0]);
        while (idx < bits.size() && cyc < 4000) begin
            if ($urandom_range(99) < duty) begin
                cfg_valid = 1'b1;
                cfg_din   = bits[idx];
                if (cfg_ready) idx++;
            end else begin
                cfg_valid = 1'b0;
                cfg_din   = 1'($urandom_range(1));
            end
            cyc++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (idx < bits.size()) begin
            check_eq("stream_timeout", TW'(idx), TW'(bits.size()));
            if (good) void'(exp_q.pop_back());
            return;
        end
        if (start_in_check) cfg_start = 1'b1;
        check_eq("check_busy", TW'(cfg_busy), TW'(1));
        check_eq("check_ready", TW'(cfg_ready), TW'(0));
        check_eq("check_no_done_yet", TW'(cfg_done), TW'(0));
        check_eq("check_lut_cfg_held", lut_cfg, prev);
        @(negedge clk);
        cfg_start = 1'b0;
        check_eq("end_busy", TW'(cfg_busy), TW'(0));
        if (good) begin
            exp_v = exp_q.pop_front();
            committed = exp_v;
            check_eq("commit_done", TW'(cfg_done), TW'(1));
            check_eq("commit_err", TW'(cfg_err), TW'(0));
            check_eq("commit_lut_cfg", lut_cfg, exp_v);
        end else begin
            check_eq("parity_no_done", TW'(cfg_done), TW'(0));
            check_eq("parity_err", TW'(cfg_err), TW'(1));
            check_eq("parity_lut_cfg_kept", lut_cfg, prev);
        end
        @(negedge clk);
        check_eq("done_one_pulse", TW'(cfg_done), TW'(0));
        check_eq("idle_after_frame", TW'(cfg_busy), TW'(0));
    endtask

    logic [W-1:0] ref_masks [N];
    logic [W-1:0] ones_masks[N];
    logic [W-1:0] rnd_masks [N];
    logic [TW-1:0] frame1_v;

    initial begin
        ref_masks  = '{16'h8000, 16'h6996, 16'hFFFE, 16'h1234};
        ones_masks = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        frame1_v   = 64'h1234_FFFE_6996_8000;

        repeat (3) @(negedge clk);
        check_eq("reset_lut_cfg_in_reset", lut_cfg, '0);
        rst_n = 1'b1;
        // Ignored bits while idle must not disturb anything.
        cfg_valid = 1'b1;
        cfg_din   = 1'b1;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b0;
        check_eq("reset_lut_cfg", lut_cfg, '0);
        check_eq("reset_ready", TW'(cfg_ready), TW'(0));
        check_eq("reset_busy", TW'(cfg_busy), TW'(0));
        check_eq("reset_done", TW'(cfg_done), TW'(0));
        check_eq("reset_err", TW'(cfg_err), TW'(0));
        check_eq("reset_state", TW'(state_dbg), TW'(0));

        run_frame(ref_masks, 100, -1, 1'b0);
        check_eq("full_load_value", lut_cfg, frame1_v);
        for (int in = 0; in < 16; in++)
            check_eq("lut0_eval", TW'(lut_cfg[in]), TW'(in == 15));

        run_frame(ref_masks, 50, -1, 1'b0);
        check_eq("backpressure_value", lut_cfg, frame1_v);

        send_partial(20);
        run_frame(ones_masks, 70, -1, 1'b0);
        check_eq("abort_all_ones", lut_cfg, {TW{1'b1}});

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) rnd_masks[i] = W'($urandom);
            run_frame(rnd_masks, $urandom_range(100, 30), -1, f == 2);
        end

`ifdef FRAC_LUT_CFG_PARITY_EN
        for (int i = 0; i < N; i++) rnd_masks[i] = W'($urandom);
        run_frame(rnd_masks, 60, 2, 1'b0);
        for (int i = 0; i < N; i++) rnd_masks[i] = W'($urandom);
        run_frame(rnd_masks, 80, -1, 1'b0);
`endif

        send_partial(10);
        #2;
        rst_n = 1'b0;
        #1;
        committed = '0;
        check_eq("midreset_lut_cfg", lut_cfg, '0);
        check_eq("midreset_busy", TW'(cfg_busy), TW'(0));
        check_eq("midreset_ready", TW'(cfg_ready), TW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) rnd_masks[i] = W'($urandom);
        run_frame(rnd_masks, 90, -1, 1'b0);

        check_eq("scoreboard_empty", TW'(exp_q.size()), TW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
